sram_arb: RTL and testbench

SRAM_ARB -- requirements
Module: sram_arb

---
 rtl/sram_arb.sv | 129 ++++++++++++
 tb/tb_sram_arb.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb.sv
// rtl/sram_arb.sv - two-master arbiter in front of a single SRAM slave
module sram_arb #(
  parameter int RR_EN  = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_axi_awaddr,
  input  logic              m0_axi_awvalid,
  output logic              m0_axi_awready,
  input  logic [DATA_W-1:0] m0_axi_wdata,
  input  logic [3:0]        m0_axi_wstrb,
  input  logic              m0_axi_wvalid,
  output logic              m0_axi_wready,
  input  logic [ADDR_W-1:0] m0_axi_araddr,
  input  logic              m0_axi_arvalid,
  output logic              m0_axi_arready,
  output logic [DATA_W-1:0] m0_axi_rdata,
  output logic              m0_axi_rvalid,
  input  logic              m0_axi_rready,
  input  logic [ADDR_W-1:0] m1_axi_awaddr,
  input  logic              m1_axi_awvalid,
  output logic              m1_axi_awready,
  input  logic [DATA_W-1:0] m1_axi_wdata,
  input  logic [3:0]        m1_axi_wstrb,
  input  logic              m1_axi_wvalid,
  output logic              m1_axi_wready,
  input  logic [ADDR_W-1:0] m1_axi_araddr,
  input  logic              m1_axi_arvalid,
  output logic              m1_axi_arready,
  output logic [DATA_W-1:0] m1_axi_rdata,
  output logic              m1_axi_rvalid,
  input  logic              m1_axi_rready,
  output logic [ADDR_W-1:0] s_axi_awaddr,
  output logic              s_axi_awvalid,
  input  logic              s_axi_awready,
  output logic [DATA_W-1:0] s_axi_wdata,
  output logic [3:0]        s_axi_wstrb,
  output logic              s_axi_wvalid,
  input  logic              s_axi_wready,
  output logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_arvalid,
  input  logic              s_axi_arready,
  input  logic [DATA_W-1:0] s_axi_rdata,
  input  logic              s_axi_rvalid,
  output logic              s_axi_rready
);

  typedef enum logic {IDLE = 1'b0, RD = 1'b1} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q, prio_d;

  logic req0, req1, gnt_vld, gnt_id, gnt_wr, gnt_rd;
  logic wr_acc, rd_acc, r_done;

  // Request decode and same-cycle grant; a write needs both AW and W present
  always_comb begin
    req0    = (m0_axi_awvalid & m0_axi_wvalid) | m0_axi_arvalid;
    req1    = (m1_axi_awvalid & m1_axi_wvalid) | m1_axi_arvalid;
    gnt_vld = (state_q == IDLE) & (req0 | req1);
    gnt_id  = (req0 & req1) ? prio_q : req1;
    gnt_wr  = gnt_vld & (gnt_id ? (m1_axi_awvalid & m1_axi_wvalid)
                                : (m0_axi_awvalid & m0_axi_wvalid));
    gnt_rd  = gnt_vld & ~gnt_wr;
    wr_acc  = gnt_wr & s_axi_awready & s_axi_wready;
    rd_acc  = gnt_rd & s_axi_arready;
    r_done  = (state_q == RD) & s_axi_rvalid & s_axi_rready;
  end

  // Slave side: only the granted master's channel is presented; idle drains stray responses
  always_comb begin
    s_axi_awaddr  = gnt_id ? m1_axi_awaddr : m0_axi_awaddr;
    s_axi_wdata   = gnt_id ? m1_axi_wdata  : m0_axi_wdata;
    s_axi_wstrb   = gnt_id ? m1_axi_wstrb  : m0_axi_wstrb;
    s_axi_araddr  = gnt_id ? m1_axi_araddr : m0_axi_araddr;
    s_axi_awvalid = gnt_wr;
    s_axi_wvalid  = gnt_wr;
    s_axi_arvalid = gnt_rd;
    s_axi_rready  = (state_q == IDLE) | (owner_q ? m1_axi_rready : m0_axi_rready);
  end

  // Master side: readies mirror the slave for the grantee, read data routed to the owner
  always_comb begin
    m0_axi_awready = gnt_wr & ~gnt_id & s_axi_awready;
    m0_axi_wready  = gnt_wr & ~gnt_id & s_axi_wready;
    m0_axi_arready = gnt_rd & ~gnt_id & s_axi_arready;
    m1_axi_awready = gnt_wr &  gnt_id & s_axi_awready;
    m1_axi_wready  = gnt_wr &  gnt_id & s_axi_wready;
    m1_axi_arready = gnt_rd &  gnt_id & s_axi_arready;
    m0_axi_rvalid  = (state_q == RD) & ~owner_q & s_axi_rvalid;
    m1_axi_rvalid  = (state_q == RD) &  owner_q & s_axi_rvalid;
    m0_axi_rdata   = s_axi_rdata;
    m1_axi_rdata   = s_axi_rdata;
  end

  // Next state: enter RD on AR accept, leave on R handshake, rotate priority on any accept
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    if (rd_acc) begin
      state_d = RD;
      owner_d = gnt_id;
    end
    if (r_done) begin
      state_d = IDLE;
    end
    if (wr_acc | rd_acc) begin
      prio_d = (RR_EN != 0) ? ~gnt_id : 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_sram_arb.sv
// tb/tb_sram_arb.sv - randomized and directed bench for sram_arb against a behavioural model
module tb_sram_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] awaddr [2];
  logic [AW-1:0] araddr [2];
  logic [DW-1:0] wdata  [2];
  logic [3:0]    wstrb  [2];
  logic          awvalid [2];
  logic          wvalid  [2];
  logic          arvalid [2];
  logic          rready  [2];
  logic          s_awready, s_wready, s_arready, s_rvalid;
  logic [DW-1:0] s_rdata;

  wire [1:0]    o_awready [2];
  wire [1:0]    o_wready  [2];
  wire [1:0]    o_arready [2];
  wire [1:0]    o_rvalid  [2];
  wire [DW-1:0] o_rdata   [2][2];
  wire [AW-1:0] o_s_awaddr [2];
  wire [AW-1:0] o_s_araddr [2];
  wire [DW-1:0] o_s_wdata  [2];
  wire [3:0]    o_s_wstrb  [2];
  wire          o_s_awvalid [2];
  wire          o_s_wvalid  [2];
  wire          o_s_arvalid [2];
  wire          o_s_rready  [2];

  // instance 0 round-robin, instance 1 fixed priority; both see identical inputs
  for (genvar k = 0; k < 2; k++) begin : g_dut
    sram_arb #(.RR_EN(k == 0 ? 1 : 0), .ADDR_W(AW), .DATA_W(DW)) u_dut (
      .clk(clk), .rst(rst),
      .m0_axi_awaddr(awaddr[0]), .m0_axi_awvalid(awvalid[0]), .m0_axi_awready(o_awready[k][0]),
      .m0_axi_wdata(wdata[0]), .m0_axi_wstrb(wstrb[0]), .m0_axi_wvalid(wvalid[0]),
      .m0_axi_wready(o_wready[k][0]), .m0_axi_araddr(araddr[0]), .m0_axi_arvalid(arvalid[0]),
      .m0_axi_arready(o_arready[k][0]), .m0_axi_rdata(o_rdata[k][0]), .m0_axi_rvalid(o_rvalid[k][0]),
      .m0_axi_rready(rready[0]),
      .m1_axi_awaddr(awaddr[1]), .m1_axi_awvalid(awvalid[1]), .m1_axi_awready(o_awready[k][1]),
      .m1_axi_wdata(wdata[1]), .m1_axi_wstrb(wstrb[1]), .m1_axi_wvalid(wvalid[1]),
      .m1_axi_wready(o_wready[k][1]), .m1_axi_araddr(araddr[1]), .m1_axi_arvalid(arvalid[1]),
      .m1_axi_arready(o_arready[k][1]), .m1_axi_rdata(o_rdata[k][1]), .m1_axi_rvalid(o_rvalid[k][1]),
      .m1_axi_rready(rready[1]),
      .s_axi_awaddr(o_s_awaddr[k]), .s_axi_awvalid(o_s_awvalid[k]), .s_axi_awready(s_awready),
      .s_axi_wdata(o_s_wdata[k]), .s_axi_wstrb(o_s_wstrb[k]), .s_axi_wvalid(o_s_wvalid[k]),
      .s_axi_wready(s_wready), .s_axi_araddr(o_s_araddr[k]), .s_axi_arvalid(o_s_arvalid[k]),
      .s_axi_arready(s_arready), .s_axi_rdata(s_rdata), .s_axi_rvalid(s_rvalid),
      .s_axi_rready(o_s_rready[k])
    );
  end

  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 0;
  bit   rnd = 0;
  int   rd_own [2] = '{-1, -1};
  int   prio   [2] = '{0, 0};
  bit   glog0 [$];
  bit   glog1 [$];
  int   n1;
  logic [31:0] mem [16];

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t actual=%h required=%h", name, k, $time, act, exp);
    end
  endtask

  // Reference: -1 means no read outstanding, otherwise the owning master
  task automatic model_cycle(input int k, output int nown, output int npri);
    bit [1:0] e_awr, e_wr, e_arr, e_rv;
    bit e_awv, e_wv, e_arv, e_rrdy, r0, r1, wr, rr;
    int g, o;
    rr = (k == 0);
    e_awr = 0; e_wr = 0; e_arr = 0; e_rv = 0;
    e_awv = 0; e_wv = 0; e_arv = 0; e_rrdy = 0;
    nown = rd_own[k];
    npri = prio[k];
    if (rd_own[k] < 0) begin
      r0 = (awvalid[0] && wvalid[0]) || arvalid[0];
      r1 = (awvalid[1] && wvalid[1]) || arvalid[1];
      g = -1;
      if (r0 && r1) g = prio[k];
      else if (r0) g = 0;
      else if (r1) g = 1;
      e_rrdy = 1;
      if (g >= 0) begin
        wr = awvalid[g] && wvalid[g];
        if (wr) begin
          e_awv = 1; e_wv = 1;
          e_awr[g] = s_awready;
          e_wr[g] = s_wready;
          if (chk_en) begin
            check("s_awaddr", k, o_s_awaddr[k], awaddr[g]);
            check("s_wdata", k, o_s_wdata[k], wdata[g]);
            check("s_wstrb", k, o_s_wstrb[k], wstrb[g]);
          end
          if (s_awready && s_wready) npri = rr ? 1 - g : 0;
        end else begin
          e_arv = 1;
          e_arr[g] = s_arready;
          if (chk_en) check("s_araddr", k, o_s_araddr[k], araddr[g]);
          if (s_arready) begin
            nown = g;
            npri = rr ? 1 - g : 0;
          end
        end
      end
    end else begin
      o = rd_own[k];
      e_rv[o] = s_rvalid;
      e_rrdy = rready[o];
      if (s_rvalid && rready[o]) nown = -1;
    end
    if (chk_en) begin
      check("ctrl", k, {o_s_awvalid[k], o_s_wvalid[k], o_s_arvalid[k], o_s_rready[k],
                        o_awready[k], o_wready[k], o_arready[k], o_rvalid[k]},
                       {e_awv, e_wv, e_arv, e_rrdy, e_awr, e_wr, e_arr, e_rv});
      check("rdata", k, {o_rdata[k][1], o_rdata[k][0]}, {s_rdata, s_rdata});
    end
    if (rst) begin
      nown = -1;
      npri = 0;
    end
  endtask

  // Every cycle: compare both instances at the negedge, log write grants, advance model at posedge
  always begin : compare
    int nown [2];
    int npri [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_cycle(k, nown[k], npri[k]);
    if (chk_en) begin
      if (o_awready[0][0] && o_wready[0][0]) glog0.push_back(1'b0);
      if (o_awready[0][1] && o_wready[0][1]) glog0.push_back(1'b1);
      if (o_awready[1][0] && o_wready[1][0]) glog1.push_back(1'b0);
      if (o_awready[1][1] && o_wready[1][1]) glog1.push_back(1'b1);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      rd_own[k] = nown[k];
      prio[k] = npri[k];
    end
  end

  // One clock; the SRAM slave model follows instance 0 and returns data one cycle after AR
  task automatic tick();
    logic w_hs, ar_hs, r_hs;
    logic [3:0] widx, ridx, ws;
    logic [DW-1:0] wd;
    @(negedge clk);
    w_hs  = o_s_awvalid[0] && s_awready && s_wready;
    ar_hs = o_s_arvalid[0] && s_arready;
    r_hs  = s_rvalid && o_s_rready[0];
    widx  = o_s_awaddr[0][5:2];
    ridx  = o_s_araddr[0][5:2];
    wd    = o_s_wdata[0];
    ws    = o_s_wstrb[0];
    @(posedge clk);
    #1;
    if (w_hs) for (int b = 0; b < 4; b++) if (ws[b]) mem[widx][8*b +: 8] = wd[8*b +: 8];
    if (r_hs) begin
      s_rvalid = 1'b0;
      s_rdata = $urandom;
    end
    if (ar_hs) begin
      s_rvalid = 1'b1;
      s_rdata = mem[ridx];
    end
    if (rnd) begin
      if (!s_rvalid && $urandom_range(0, 15) == 0) begin
        s_rvalid = 1'b1;
        s_rdata = $urandom;
      end
      s_awready = ($urandom_range(0, 3) != 0);
      s_wready  = s_awready;
      s_arready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic idle_masters();
    for (int m = 0; m < 2; m++) begin
      awvalid[m] = 0; wvalid[m] = 0; arvalid[m] = 0; rready[m] = 0;
      awaddr[m] = 0; araddr[m] = 0; wdata[m] = 0; wstrb[m] = 0;
    end
  endtask

  task automatic do_reset();
    idle_masters();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    idle_masters();
    s_awready = 1; s_wready = 1; s_arready = 1; s_rvalid = 0; s_rdata = 0;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    rst = 1;
    tick();
    chk_en = 1;
    #3;
    for (int k = 0; k < 2; k++)
      check("reset_ctrl", k, {o_s_awvalid[k], o_s_wvalid[k], o_s_arvalid[k], o_s_rready[k],
                              o_awready[k], o_wready[k], o_arready[k], o_rvalid[k]}, 12'h100);
    do_reset();

    // m0 write then read back
    awvalid[0] = 1; wvalid[0] = 1; awaddr[0] = 32'h10; wdata[0] = 32'hA5A5A5A5; wstrb[0] = 4'hF;
    #3;
    for (int k = 0; k < 2; k++) check("wr_ready", k, {o_awready[k][0], o_wready[k][0]}, 2'b11);
    tick();
    idle_masters();
    arvalid[0] = 1; araddr[0] = 32'h10;
    #3;
    for (int k = 0; k < 2; k++) check("ar_ready", k, o_arready[k], 2'b01);
    tick();
    arvalid[0] = 0; rready[0] = 1;
    #3;
    for (int k = 0; k < 2; k++) begin
      check("rd_valid", k, o_rvalid[k], 2'b01);
      check("rd_data", k, o_rdata[k][0], 32'hA5A5A5A5);
    end
    tick();

    // both masters write every cycle
    do_reset();
    glog0.delete();
    glog1.delete();
    for (int m = 0; m < 2; m++) begin
      awvalid[m] = 1; wvalid[m] = 1; awaddr[m] = 32'h20 + 4 * m; wdata[m] = 32'h100 + m; wstrb[m] = 4'hF;
    end
    for (int i = 0; i < 8; i++) tick();
    check("rr_len", 0, glog0.size(), 8);
    if (glog0.size() >= 4) check("rr_order", 0, {glog0[0], glog0[1], glog0[2], glog0[3]}, 4'b0101);
    check("fp_len", 1, glog1.size(), 8);
    n1 = 0;
    foreach (glog1[i]) n1 += int'(glog1[i]);
    check("fp_m1_grants", 1, n1, 0);

    // pending m1 read blocks an m0 write
    do_reset();
    arvalid[1] = 1; araddr[1] = 32'h10;
    tick();
    arvalid[1] = 0;
    awvalid[0] = 1; wvalid[0] = 1; awaddr[0] = 32'h30; wdata[0] = 32'h12345678; wstrb[0] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #3;
      for (int k = 0; k < 2; k++) begin
        check("blk_wready", k, o_wready[k][0], 1'b0);
        check("blk_rvalid", k, o_rvalid[k], 2'b10);
        check("blk_rdata", k, o_rdata[k][1], 32'hA5A5A5A5);
      end
      tick();
    end
    rready[1] = 1;
    #3;
    for (int k = 0; k < 2; k++) check("hs_wready", k, o_wready[k][0], 1'b0);
    tick();
    rready[1] = 0;
    #3;
    for (int k = 0; k < 2; k++) check("post_rd_wr", k, {o_awready[k][0], o_wready[k][0]}, 2'b11);
    tick();

    // half-presented write is no request
    do_reset();
    awvalid[0] = 1; awaddr[0] = 32'h10; arvalid[1] = 1; araddr[1] = 32'h30;
    #3;
    for (int k = 0; k < 2; k++) begin
      check("half_ar", k, o_arready[k], 2'b10);
      check("half_aw", k, o_awready[k], 2'b00);
    end
    tick();
    idle_masters();
    rready[1] = 1;
    #3;
    for (int k = 0; k < 2; k++) check("half_rdata", k, {o_rvalid[k], o_rdata[k][1]}, {2'b10, 32'h12345678});
    tick();

    // reset while a read is outstanding
    do_reset();
    arvalid[0] = 1; araddr[0] = 32'h10;
    tick();
    arvalid[0] = 0;
    #3;
    for (int k = 0; k < 2; k++) check("pre_rst_rv", k, o_rvalid[k], 2'b01);
    rst = 1;
    tick();
    rst = 0;
    #3;
    for (int k = 0; k < 2; k++) check("late_rv", k, {o_rvalid[k], o_s_rready[k]}, 3'b001);
    rready[0] = 1;
    tick();
    #3;
    for (int k = 0; k < 2; k++) check("drained_rv", k, o_rvalid[k], 2'b00);

    // random traffic against the model
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < 2; m++) begin
        awvalid[m] = ($urandom_range(0, 3) == 0);
        wvalid[m]  = ($urandom_range(0, 3) == 0) ? !awvalid[m] : awvalid[m];
        arvalid[m] = ($urandom_range(0, 3) == 0);
        rready[m]  = $urandom_range(0, 1) != 0;
        awaddr[m]  = 32'($urandom_range(0, 15)) << 2;
        araddr[m]  = 32'($urandom_range(0, 15)) << 2;
        wdata[m]   = $urandom;
        wstrb[m]   = 4'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rnd = 0;
    rst = 0;
    idle_masters();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
